// File: rtl/multiplicador_filtro.sv
// Sequential shift-add fixed-point multiplier with symmetric saturation for the filter datapath.
// Define MULT_FILTRO_ROUND_EN to round half away from zero instead of truncating toward zero.
module multiplicador_filtro #(
  parameter int Width    = 22,
  parameter int FracBits = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [Width-1:0] A,
  input  logic signed [Width-1:0] B,
  output logic signed [Width-1:0] Y,
  output logic                    busy,
  output logic                    done
);

  localparam int CntW = $clog2(Width + 1);
  localparam int AccW = 2 * Width;
  localparam logic [AccW-1:0] MAXIMO = {{(Width + 1){1'b0}}, {(Width - 1){1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t                   state_q;
  logic [AccW-1:0]          acc_q;
  logic [AccW-1:0]          mcand_q;
  logic [Width-1:0]         mplier_q;
  logic [CntW-1:0]          cnt_q;
  logic                     sign_q;
  logic signed [Width-1:0]  y_q;
  logic                     busy_q;
  logic                     done_q;

  logic [AccW-1:0]          acc_d;
  logic signed [Width-1:0]  y_d;
  logic                     sign_d;

  function automatic logic [Width-1:0] magnitude(input logic signed [Width-1:0] v);
    logic signed [Width-1:0] neg;
    neg = -v;
    return v[Width-1] ? unsigned'(neg) : unsigned'(v);
  endfunction

  // Rescale the unsigned product to the Q format, then clamp so -2^(Width-1) is unreachable.
  function automatic logic signed [Width-1:0] normalize(input logic [AccW-1:0] prod,
                                                        input logic neg);
    logic [AccW-1:0]  m;
    logic [Width-1:0] r;
    m = prod;
`ifdef MULT_FILTRO_ROUND_EN
    m = m + (AccW'(1) << (FracBits - 1));
`endif
    m = m >> FracBits;
    if (m > MAXIMO) m = MAXIMO;
    r = m[Width-1:0];
    return neg ? -signed'(r) : signed'(r);
  endfunction

  always_comb begin
    acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    y_d    = normalize(acc_q, sign_q);
    sign_d = (A[Width-1] ^ B[Width-1]) && (A != '0) && (B != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{Width{1'b0}}, magnitude(A)};
            mplier_q <= magnitude(B);
            sign_q   <= sign_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntW'(Width - 1)) state_q <= NORM;
        end
        NORM: begin
          y_q     <= y_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador_filtro.sv
// Self-checking bench for multiplicador_filtro: directed corner cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_multiplicador_filtro;

  localparam int W = 22;
  localparam int F = 11;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic signed [W-1:0] Y;
  logic                busy;
  logic                done;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multiplicador_filtro #(.Width(W), .FracBits(F)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact product, scaled by 2^-F toward zero (or half away from zero), clamped symmetrically.
  function automatic longint model(input longint a, input longint b);
    longint p, mag;
    p   = a * b;
    mag = (p < 0) ? -p : p;
`ifdef MULT_FILTRO_ROUND_EN
    mag = mag + (64'sd1 <<< (F - 1));
`endif
    mag = mag / (64'sd1 <<< F);
    if (mag > MAXV) mag = MAXV;
    return (p < 0) ? -mag : mag;
  endfunction

  // Launch one multiplication, optionally glitch start/operands mid-operation, verify timing and Y.
  task automatic run_op(input string tag, input longint a, input longint b,
                        input int glitch_at, input longint exp);
    int lat;
    bit busy_ok;
    bit seen;
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = (busy === 1'b1);
    lat = 0;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k == glitch_at) begin
        start = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
      end else if (k == glitch_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1;
        lat = k;
      end else if (busy !== 1'b1) begin
        busy_ok = 0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, lat, W + 1);
    check({tag, " busy_hold"}, busy_ok, 1);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " Y"}, Y, exp);
  endtask

  initial begin
    logic signed [W-1:0] ra, rb;
    logic signed [W-1:0] y_hold;
    int                  dones;
    bit                  quiet;

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #22;
    check("reset Y", Y, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("unity", 2048, 2048, 0, 2048);
    run_op("sign", -3072, 4096, 0, -6144);
    run_op("neg_min_sat", -2097152, 2048, 0, -2097151);
    run_op("ovf_pos", 1048576, 1048576, 0, 2097151);
    run_op("ovf_neg", -1048576, 1048576, 0, -2097151);
`ifdef MULT_FILTRO_ROUND_EN
    run_op("round_pos", 3, 1024, 0, 2);
    run_op("round_neg", -3, 1024, 0, -2);
`else
    run_op("round_pos", 3, 1024, 0, 1);
    run_op("round_neg", -3, 1024, 0, -1);
`endif
    run_op("zero_a_neg_b", 0, -5000, 0, 0);
    run_op("neg_zero", -4096, 0, 0, 0);
    run_op("min_times_min", -2097152, -2097152, 0, 2097151);

    // Start and new operands mid-operation must be ignored; then a back-to-back start.
    run_op("ignored_start", 5000, -7000, 5, model(5000, -7000));
    check("b2b done_high", done, 1);
    run_op("back_to_back", -1234, 5678, 0, model(-1234, 5678));

    y_hold = Y;
    quiet = 1;
    repeat (8) begin
      @(posedge clk); #1;
      if (Y !== y_hold || done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    check("idle_hold", quiet, 1);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 3 == 1) rb = W'($signed($urandom_range(0, 8191)) - 4096);
      run_op("random", ra, rb, 0, model(ra, rb));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Abort mid-CALC: outputs clear at once and no done follows.
    A = W'(300000);
    B = W'(-9000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort Y", Y, 0);
    check("abort done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    quiet = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
      if (busy !== 1'b0) quiet = 0;
    end
    check("abort no_done", dones, 0);
    check("abort stays_idle", quiet, 1);

    // Start held through reset release is taken on the first edge with reset low.
    reset = 1'b1;
    start = 1'b1;
    A = W'(-7777);
    B = W'(3333);
    @(negedge clk);
    reset = 1'b0;
    run_op("start_thru_reset", -7777, 3333, 0, model(-7777, 3333));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
